// File: rtl/config_loader_pkg.sv
// Shared types and sizing constants for the configuration loader.
package config_loader_pkg;

  localparam int DEF_NUM_WORDS = 33;
  localparam int DEF_WORD_W    = 32;
  localparam int TIMER_W       = 4;

  // Width needed to hold a slot count from 0 up to and including n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_COUNT_W = count_width(DEF_NUM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/config_loader_if.sv
// Word-stream and latch-bus signals between a controller and the loader.
interface config_loader_if
  import config_loader_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = DEF_WORD_W
) ();

  localparam int COUNT_W = count_width(NUM_WORDS);

  logic                 io_start;
  logic                 io_abort;
  logic                 io_word_valid;
  logic [WORD_W-1:0]    io_word_bits;
  logic                 io_word_ready;
  logic [WORD_W-1:0]    io_d_out;
  logic [NUM_WORDS-1:0] io_configs_en;
  logic                 io_busy;
  logic                 io_done;
  logic [COUNT_W-1:0]   io_count;

  modport master (
    output io_start, io_abort, io_word_valid, io_word_bits,
    input  io_word_ready, io_d_out, io_configs_en, io_busy, io_done, io_count
  );

  modport slave (
    input  io_start, io_abort, io_word_valid, io_word_bits,
    output io_word_ready, io_d_out, io_configs_en, io_busy, io_done, io_count
  );

endinterface

// File: rtl/config_strobe_timer.sv
// Down-counter that times how long a latch enable stays high.
module config_strobe_timer
  import config_loader_pkg::*;
#(
  parameter int STROBE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [TIMER_W-1:0] cnt;

  // Load the strobe length, then count down once per strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TIMER_W'(STROBE_CYCLES);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  // Terminal count of 1 marks the last strobe cycle.
  assign expired = tick && (cnt == TIMER_W'(1));

endmodule

// File: rtl/config_loader.sv
// Streams NUM_WORDS words onto a shared bus and pulses one latch enable per
// word, keeping the bus stable whenever any enable is high.
//
//   state     | meaning
//   IDLE      | waiting for start, bus holds last word
//   WAIT_WORD | ready high, waiting for the next word
//   SETUP     | new word on bus, enables low
//   STROBE    | enable of current slot high for STROBE_CYCLES
//   HOLD      | enables low again, bus still stable
//   DONE      | one-cycle completion pulse
module config_loader
  import config_loader_pkg::*;
#(
  parameter int NUM_WORDS     = DEF_NUM_WORDS,
  parameter int WORD_W        = DEF_WORD_W,
  parameter int STROBE_CYCLES = 1
) (
  input logic            clk,
  input logic            reset,
  config_loader_if.slave bus
);

  localparam int                   COUNT_W  = count_width(NUM_WORDS);
  localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);
  localparam logic [COUNT_W-1:0]   LAST_IDX = COUNT_W'(NUM_WORDS - 1);

  state_t             state;
  logic [COUNT_W-1:0] index;
  logic               strobe_expired;

  config_strobe_timer #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state == ST_SETUP),
    .tick   (state == ST_STROBE),
    .expired(strobe_expired)
  );

  // Sequencer with every output registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      index             <= '0;
      bus.io_d_out      <= '0;
      bus.io_configs_en <= '0;
      bus.io_word_ready <= 1'b0;
      bus.io_busy       <= 1'b0;
      bus.io_done       <= 1'b0;
      bus.io_count      <= '0;
    end else if (bus.io_abort && (state != ST_IDLE)) begin
      // Abort wins over any accept in the same cycle; count is kept.
      state             <= ST_IDLE;
      bus.io_configs_en <= '0;
      bus.io_word_ready <= 1'b0;
      bus.io_busy       <= 1'b0;
      bus.io_done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.io_done <= 1'b0;
          if (bus.io_start) begin
            state             <= ST_WAIT_WORD;
            index             <= '0;
            bus.io_count      <= '0;
            bus.io_word_ready <= 1'b1;
            bus.io_busy       <= 1'b1;
          end
        end
        ST_WAIT_WORD: begin
          if (bus.io_word_valid) begin
            state             <= ST_SETUP;
            bus.io_d_out      <= WORD_W'(bus.io_word_bits);
            bus.io_word_ready <= 1'b0;
          end
        end
        ST_SETUP: begin
          state             <= ST_STROBE;
          bus.io_configs_en <= EN_ONE << index;
        end
        ST_STROBE: begin
          if (strobe_expired) begin
            state             <= ST_HOLD;
            bus.io_configs_en <= '0;
          end
        end
        ST_HOLD: begin
          index        <= index + COUNT_W'(1);
          bus.io_count <= bus.io_count + COUNT_W'(1);
          if (index == LAST_IDX) begin
            state       <= ST_DONE;
            bus.io_done <= 1'b1;
          end else begin
            state             <= ST_WAIT_WORD;
            bus.io_word_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          bus.io_done <= 1'b0;
          bus.io_busy <= 1'b0;
        end
        default: begin
          state             <= ST_IDLE;
          bus.io_configs_en <= '0;
          bus.io_word_ready <= 1'b0;
          bus.io_busy       <= 1'b0;
          bus.io_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench: full loads, back-pressure, abort, reset and a long-strobe
// instance, with continuous one-hot and bus-stability monitors.
module tb_config_loader;
  import config_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  config_loader_if #(.NUM_WORDS(33), .WORD_W(32)) ifa ();
  config_loader_if #(.NUM_WORDS(4),  .WORD_W(32)) ifb ();

  config_loader #(.NUM_WORDS(33), .WORD_W(32), .STROBE_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  config_loader #(.NUM_WORDS(4),  .WORD_W(32), .STROBE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wval(input int k);
    return 32'hA500_0000 + 32'(k);
  endfunction

  int cyc_g = 0;
  always @(posedge clk) cyc_g++;

  // Monitor A: one-hot enables, no bus change on an enable rise, slot/data pairing.
  logic [32:0] prev_en_a = '0;
  logic [31:0] prev_d_a  = '0;
  int          hits_a[33];
  int          done_pulses_a = 0;
  always @(negedge clk) begin
    checks++;
    assert ($onehot0(ifa.io_configs_en)) else begin
      errors++;
      $error("FAIL a_onehot observed 0x%0h expected at most one bit", ifa.io_configs_en);
    end
    if ((ifa.io_configs_en & ~prev_en_a) != '0) begin
      checks++;
      assert (ifa.io_d_out === prev_d_a) else begin
        errors++;
        $error("FAIL a_rise_stable observed 0x%0h expected 0x%0h", ifa.io_d_out, prev_d_a);
      end
    end
    for (int i = 0; i < 33; i++) begin
      if (ifa.io_configs_en[i]) begin
        checks++;
        assert (ifa.io_d_out === wval(i)) else begin
          errors++;
          $error("FAIL a_slot_data observed 0x%0h expected 0x%0h", ifa.io_d_out, wval(i));
        end
        if (!prev_en_a[i]) hits_a[i]++;
      end
    end
    if (ifa.io_done) done_pulses_a++;
    prev_en_a = ifa.io_configs_en;
    prev_d_a  = ifa.io_d_out;
  end

  // Monitor B: same invariants plus enable-high length and accept spacing.
  logic [3:0]  prev_en_b = '0;
  logic [31:0] prev_d_b  = '0;
  int          hi_b[4];
  int          acc_t_b[8];
  int          acc_n_b = 0;
  int          done_pulses_b = 0;
  always @(negedge clk) begin
    checks++;
    assert ($onehot0(ifb.io_configs_en)) else begin
      errors++;
      $error("FAIL b_onehot observed 0x%0h expected at most one bit", ifb.io_configs_en);
    end
    if ((ifb.io_configs_en & ~prev_en_b) != '0) begin
      checks++;
      assert (ifb.io_d_out === prev_d_b) else begin
        errors++;
        $error("FAIL b_rise_stable observed 0x%0h expected 0x%0h", ifb.io_d_out, prev_d_b);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ifb.io_configs_en[i]) begin
        hi_b[i]++;
        checks++;
        assert (ifb.io_d_out === wval(i)) else begin
          errors++;
          $error("FAIL b_slot_data observed 0x%0h expected 0x%0h", ifb.io_d_out, wval(i));
        end
      end
    end
    if (ifb.io_word_ready && ifb.io_word_valid && acc_n_b < 8) begin
      acc_t_b[acc_n_b] = cyc_g;
      acc_n_b++;
    end
    if (ifb.io_done) done_pulses_b++;
    prev_en_b = ifb.io_configs_en;
    prev_d_b  = ifb.io_d_out;
  end

  int ka;
  int kb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on A; advance the offered word when the edge accepted one.
  task automatic step_a();
    logic acc;
    acc = ifa.io_word_ready && ifa.io_word_valid && !ifa.io_abort && !reset;
    tick();
    ifa.io_start = 1'b0;
    if (acc) begin
      ka++;
      ifa.io_word_bits = wval(ka);
    end
  endtask

  task automatic step_b();
    logic acc;
    acc = ifb.io_word_ready && ifb.io_word_valid && !ifb.io_abort && !reset;
    tick();
    ifb.io_start = 1'b0;
    if (acc) begin
      kb++;
      ifb.io_word_bits = wval(kb);
    end
  endtask

  // Full sequence on A; optionally drop valid for gap_len cycles right after
  // word gap_k-1 is accepted. Returns the cycle (start cycle = 0) showing done.
  task automatic run_a(input int gap_k, input int gap_len, output int done_cyc);
    int cyc;
    bit gap_done;
    cyc      = 0;
    gap_done = 1'b0;
    done_cyc = -1;
    ka = 0;
    ifa.io_word_bits  = wval(0);
    ifa.io_word_valid = 1'b1;
    ifa.io_start      = 1'b1;
    while (done_cyc < 0 && cyc < 400) begin
      step_a();
      cyc++;
      if (ifa.io_done) done_cyc = cyc;
      if (gap_len > 0 && !gap_done && ka == gap_k) begin
        gap_done = 1'b1;
        ifa.io_word_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          if (g == 5) ifa.io_start = 1'b1;
          step_a();
          cyc++;
        end
        chk("bp_ready",  64'(ifa.io_word_ready), 64'd1);
        chk("bp_en_low", 64'(ifa.io_configs_en), 64'd0);
        chk("bp_d_hold", 64'(ifa.io_d_out), 64'(wval(gap_k - 1)));
        chk("bp_count",  64'(ifa.io_count), 64'(gap_k));
        chk("bp_busy",   64'(ifa.io_busy), 64'd1);
        ifa.io_word_valid = 1'b1;
      end
    end
  endtask

  function automatic int bad_hits_a();
    int bad = 0;
    for (int i = 0; i < 33; i++) if (hits_a[i] != 1) bad++;
    return bad;
  endfunction

  task automatic clear_hits_a();
    for (int i = 0; i < 33; i++) hits_a[i] = 0;
  endtask

  initial begin
    int dc;
    int pulses;
    int guard;

    reset = 1'b1;
    ifa.io_start = 1'b0; ifa.io_abort = 1'b0; ifa.io_word_valid = 1'b0; ifa.io_word_bits = '0;
    ifb.io_start = 1'b0; ifb.io_abort = 1'b0; ifb.io_word_valid = 1'b0; ifb.io_word_bits = '0;
    for (int i = 0; i < 4; i++) hi_b[i] = 0;
    clear_hits_a();
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_d_out", 64'(ifa.io_d_out), 64'd0);
    chk("rst_en",    64'(ifa.io_configs_en), 64'd0);
    chk("rst_ready", 64'(ifa.io_word_ready), 64'd0);
    chk("rst_busy",  64'(ifa.io_busy), 64'd0);
    chk("rst_done",  64'(ifa.io_done), 64'd0);
    chk("rst_count", 64'(ifa.io_count), 64'd0);

    // Abort while idle does nothing.
    ifa.io_abort = 1'b1;
    step_a();
    ifa.io_abort = 1'b0;
    chk("idle_abort_busy", 64'(ifa.io_busy), 64'd0);

    // Full load: 4 cycles per word, done visible in cycle 133.
    run_a(-1, 0, dc);
    chk("full_done_cyc", 64'(dc), 64'd133);
    chk("full_count",    64'(ifa.io_count), 64'd33);
    chk("full_words",    64'(ka), 64'd33);
    // Start arriving in the DONE cycle is ignored.
    ifa.io_start = 1'b1;
    step_a();
    chk("done_pulse_len", 64'(ifa.io_done), 64'd0);
    chk("done_start_ign", 64'(ifa.io_busy), 64'd0);
    chk("done_start_rdy", 64'(ifa.io_word_ready), 64'd0);
    step_a();
    chk("full_hits",  64'(bad_hits_a()), 64'd0);
    chk("full_pulse", 64'(done_pulses_a), 64'd1);

    // Back-pressure: 10 low-valid cycles, 3 of them overlap word 4's
    // setup/strobe/hold, so completion slips by 7 cycles to cycle 140.
    clear_hits_a();
    run_a(5, 10, dc);
    chk("bp_done_cyc", 64'(dc), 64'd140);
    chk("bp_count_end", 64'(ifa.io_count), 64'd33);
    step_a();
    step_a();
    chk("bp_hits", 64'(bad_hits_a()), 64'd0);

    // Abort during strobe of slot 7.
    ka = 0;
    ifa.io_word_bits  = wval(0);
    ifa.io_word_valid = 1'b1;
    ifa.io_start      = 1'b1;
    guard = 0;
    while (!ifa.io_configs_en[7] && guard < 100) begin
      step_a();
      guard++;
    end
    chk("ab_reached", 64'(ifa.io_configs_en), 64'h80);
    pulses = done_pulses_a;
    ifa.io_abort = 1'b1;
    step_a();
    ifa.io_abort = 1'b0;
    chk("ab_en",    64'(ifa.io_configs_en), 64'd0);
    chk("ab_busy",  64'(ifa.io_busy), 64'd0);
    chk("ab_ready", 64'(ifa.io_word_ready), 64'd0);
    chk("ab_count", 64'(ifa.io_count), 64'd7);
    for (int i = 0; i < 6; i++) step_a();
    chk("ab_no_done", 64'(done_pulses_a), 64'(pulses));
    chk("ab_idle",    64'(ifa.io_busy), 64'd0);

    // Abort coinciding with an accept discards the word.
    ka = 0;
    ifa.io_word_bits = wval(0);
    ifa.io_start     = 1'b1;
    step_a();
    chk("aa_ready", 64'(ifa.io_word_ready), 64'd1);
    ifa.io_abort = 1'b1;
    step_a();
    ifa.io_abort = 1'b0;
    chk("aa_d_kept", 64'(ifa.io_d_out), 64'(wval(7)));
    chk("aa_busy",   64'(ifa.io_busy), 64'd0);
    chk("aa_count",  64'(ifa.io_count), 64'd0);
    step_a();

    // Reset in HOLD of slot 12, together with abort and start.
    ka = 0;
    ifa.io_word_bits = wval(0);
    ifa.io_start     = 1'b1;
    guard = 0;
    while (!ifa.io_configs_en[12] && guard < 100) begin
      step_a();
      guard++;
    end
    step_a();
    chk("rh_in_hold", 64'(ifa.io_configs_en), 64'd0);
    chk("rh_count",   64'(ifa.io_count), 64'd12);
    reset = 1'b1;
    ifa.io_abort = 1'b1;
    ifa.io_start = 1'b1;
    step_a();
    chk("rh_d_out", 64'(ifa.io_d_out), 64'd0);
    chk("rh_en",    64'(ifa.io_configs_en), 64'd0);
    chk("rh_ready", 64'(ifa.io_word_ready), 64'd0);
    chk("rh_busy",  64'(ifa.io_busy), 64'd0);
    chk("rh_done",  64'(ifa.io_done), 64'd0);
    chk("rh_count0", 64'(ifa.io_count), 64'd0);
    reset = 1'b0;
    ifa.io_abort = 1'b0;
    step_a();
    chk("rh_still_idle", 64'(ifa.io_busy), 64'd0);
    clear_hits_a();
    run_a(-1, 0, dc);
    chk("rh_reload_cyc",   64'(dc), 64'd133);
    chk("rh_reload_count", 64'(ifa.io_count), 64'd33);
    step_a();
    step_a();
    chk("rh_reload_hits", 64'(bad_hits_a()), 64'd0);

    // Instance B: 4-cycle strobes, 7-cycle word period, done in cycle 29.
    chk("b_rst_busy", 64'(ifb.io_busy), 64'd0);
    kb = 0;
    ifb.io_word_bits  = wval(0);
    ifb.io_word_valid = 1'b1;
    ifb.io_start      = 1'b1;
    dc = -1;
    guard = 0;
    while (dc < 0 && guard < 100) begin
      step_b();
      guard++;
      if (ifb.io_done) dc = guard;
    end
    chk("b_done_cyc", 64'(dc), 64'd29);
    chk("b_count",    64'(ifb.io_count), 64'd4);
    step_b();
    step_b();
    for (int i = 0; i < 4; i++) chk($sformatf("b_hi_len%0d", i), 64'(hi_b[i]), 64'd4);
    chk("b_accepts", 64'(acc_n_b), 64'd4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("b_period%0d", i), 64'(acc_t_b[i] - acc_t_b[i-1]), 64'd7);
    chk("b_pulses", 64'(done_pulses_b), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
